// File: rtl/rv_pkg.sv
// Shared fetch-path types: FSM state encoding, instruction/PC constants and
// the prefetch entry layout used by fetch_unit and its FIFO.
package rv_pkg;

    localparam int INST_W  = 32;
    localparam int PC_STEP = 4;
    localparam int PC_W    = 32;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's memory, redirect and decode-side channels.
// master = fetch unit side, slave = memory/branch/decode side.
interface fetch_unit_if #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4
);
    import rv_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              imem_req_valid;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_req_ready;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [XLEN-1:0]   inst_pc;
    logic [XLEN-1:0]   inst_pc_plus4;
    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst_data, inst_pc, inst_pc_plus4, fifo_count,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst_data, inst_pc, inst_pc_plus4, fifo_count,
        output inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer with zero-latency head output and a synchronous
// flush that empties it in the cycle it is asserted.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic                   valid_o,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push_i && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the head is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign valid_o = (count_q != '0);
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one request at a time
// to a variable-latency memory, and buffers tagged instructions for decode.
module fetch_unit
    import rv_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic clk,
    input  logic reset,
    fetch_unit_if.master bus
);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = $bits(fetch_entry_t);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            started_q;

    logic             req_valid, req_fire, push;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   in_flight;
    logic             credit_ok;
    fetch_entry_t     push_entry, head_entry;
    logic [ENTRY_W-1:0] head_bits;
    logic             head_valid;

    // A request still in WAIT already owns a FIFO slot.
    assign in_flight = {1'b0, fifo_count} + {{CNT_W{1'b0}}, (state_q == WAIT)};
    assign credit_ok = in_flight < (CNT_W + 1)'(FIFO_DEPTH);
    assign req_fire  = req_valid && bus.imem_req_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        req_valid  = 1'b0;
        push       = 1'b0;

        unique case (state_q)
            ISSUE: req_valid = started_q && credit_ok;
            WAIT:  req_valid = bus.imem_rsp_valid && credit_ok;
            default: req_valid = 1'b0;
        endcase

        unique case (state_q)
            ISSUE: begin
                if (req_fire) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    push = 1'b1;
                    if (req_fire) begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            FLUSH: begin
                if (bus.imem_rsp_valid) state_d = ISSUE;
            end
            default: state_d = ISSUE;
        endcase

        // Redirect wins: anything accepted this cycle becomes a debt to FLUSH.
        if (bus.redirect_valid) begin
            push       = 1'b0;
            fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
            unique case (state_q)
                ISSUE:   state_d = req_fire ? FLUSH : ISSUE;
                WAIT:    state_d = (bus.imem_rsp_valid && !req_fire) ? ISSUE : FLUSH;
                // The owed word arriving now settles the debt; otherwise keep waiting.
                FLUSH:   state_d = bus.imem_rsp_valid ? ISSUE : FLUSH;
                default: state_d = ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ISSUE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            started_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            started_q  <= 1'b1;
        end
    end

    assign push_entry = '{inst:     bus.imem_rsp_data,
                          pc:       req_pc_q,
                          pc_plus4: req_pc_q + XLEN'(PC_STEP)};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .flush_i     (bus.redirect_valid),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (bus.inst_ready),
        .valid_o     (head_valid),
        .head_o      (head_bits),
        .count_o     (fifo_count)
    );

    assign head_entry = fetch_entry_t'(head_bits);

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.inst_valid     = head_valid;
    assign bus.inst_data      = head_entry.inst;
    assign bus.inst_pc        = head_entry.pc;
    assign bus.inst_pc_plus4  = head_entry.pc_plus4;
    assign bus.fifo_count     = fifo_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural variable-latency memory
// that returns addr ^ 32'hA5A5_0000.
module tb_fetch_unit;
    import rv_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(32), .FIFO_DEPTH(4)) bus ();

    fetch_unit #(
        .XLEN       (32),
        .FIFO_DEPTH (4),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned mem_lat = 1;
    logic        mem_pend;
    int unsigned mem_wait;
    logic [31:0] mem_addr;

    assign bus.imem_rsp_valid = mem_pend && (mem_wait == 0);
    assign bus.imem_rsp_data  = mem_addr ^ 32'hA5A5_0000;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_pend <= 1'b0;
            mem_wait <= 0;
            mem_addr <= '0;
        end else begin
            if (bus.imem_rsp_valid) mem_pend <= 1'b0;
            else if (mem_pend)      mem_wait <= mem_wait - 1;
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mem_pend <= 1'b1;
                mem_wait <= mem_lat - 1;
                mem_addr <= bus.imem_req_addr;
            end
        end
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b1;

        // Reset state
        #2;
        check("rst req_valid",  32'(bus.imem_req_valid), 32'd0);
        check("rst req_addr",   bus.imem_req_addr,        32'h0);
        check("rst inst_valid", 32'(bus.inst_valid),      32'd0);
        check("rst fifo_count", 32'(bus.fifo_count),      32'd0);
        check("rst inst_data",  bus.inst_data,            32'h0);
        check("rst inst_pc",    bus.inst_pc,              32'h0);
        check("rst pc_plus4",   bus.inst_pc_plus4,        32'h0);
        step();
        reset = 1'b1;

        // 1-cycle memory, streaming one instruction per cycle
        step();
        check("t1 first req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t1 first req_addr",  bus.imem_req_addr,        32'h0);
        for (int i = 0; i < 20 && !bus.inst_valid; i++) step();
        check("t1 inst_valid seen", 32'(bus.inst_valid), 32'd1);
        for (int k = 0; k < 6; k++) begin
            check("t1 stream valid",  32'(bus.inst_valid), 32'd1);
            check("t1 stream pc",     bus.inst_pc,         32'(k * 4));
            check("t1 stream plus4",  bus.inst_pc_plus4,   32'(k * 4 + 4));
            check("t1 stream data",   bus.inst_data,       32'(k * 4) ^ 32'hA5A5_0000);
            step();
        end

        // Back-pressure fills the FIFO, then drains in order
        bus.inst_ready = 1'b0;
        do_reset();
        repeat (12) step();
        check("t2 full count",   32'(bus.fifo_count),     32'd4);
        check("t2 req stopped",  32'(bus.imem_req_valid), 32'd0);
        bus.inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t2 drain valid", 32'(bus.inst_valid), 32'd1);
            check("t2 drain pc",    bus.inst_pc,         32'(k * 4));
            step();
        end

        // 3-cycle memory, redirect while 0x8 is outstanding
        mem_lat = 3;
        do_reset();
        for (int i = 0; i < 40 && !(bus.imem_req_valid && bus.imem_req_addr == 32'h8); i++) step();
        check("t3 req 0x8 seen", 32'(bus.imem_req_valid), 32'd1);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        check("t3 flushed valid", 32'(bus.inst_valid), 32'd0);
        check("t3 flushed count", 32'(bus.fifo_count), 32'd0);
        for (int i = 0; i < 30 && !bus.imem_req_valid; i++) step();
        check("t3 redirect addr", bus.imem_req_addr, 32'h100);
        for (int i = 0; i < 30 && !bus.inst_valid; i++) step();
        check("t3 next inst_pc",   bus.inst_pc,   32'h100);
        check("t3 next inst_data", bus.inst_data, 32'h100 ^ 32'hA5A5_0000);

        // Redirect coincident with the response for 0x10
        do_reset();
        for (int i = 0; i < 60 && !(bus.imem_rsp_valid && mem_addr == 32'h10); i++) step();
        check("t4 rsp 0x10 seen", 32'(bus.imem_rsp_valid), 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        step();
        bus.redirect_valid = 1'b0;
        check("t4 empty valid", 32'(bus.inst_valid), 32'd0);
        check("t4 empty count", 32'(bus.fifo_count), 32'd0);
        for (int i = 0; i < 30 && !bus.inst_valid; i++) step();
        check("t4 next inst_pc", bus.inst_pc, 32'h300);

        // Misaligned redirect target is word-aligned
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h203;
        step();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 30 && !bus.imem_req_valid; i++) step();
        check("t5 aligned addr", bus.imem_req_addr, 32'h200);
        for (int i = 0; i < 30 && !bus.inst_valid; i++) step();
        check("t5 inst_pc",    bus.inst_pc,       32'h200);
        check("t5 inst_plus4", bus.inst_pc_plus4, 32'h204);

        // PC wraps at the top of the address space
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 30 && !bus.inst_valid; i++) step();
        check("t6 top inst_pc",    bus.inst_pc,       32'hFFFF_FFFC);
        check("t6 top inst_plus4", bus.inst_pc_plus4, 32'h0);
        step();
        for (int i = 0; i < 30 && !bus.inst_valid; i++) step();
        check("t6 wrapped inst_pc", bus.inst_pc, 32'h0);

        // Asynchronous reset mid-WAIT with credit exhausted
        mem_lat = 5;
        bus.inst_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 80 && bus.fifo_count != 3'd3; i++) step();
        check("t7 count before", 32'(bus.fifo_count), 32'd3);
        step();
        check("t7 inst_valid before", 32'(bus.inst_valid), 32'd1);
        #3;
        reset = 1'b0;
        #2;
        check("t7 async inst_valid", 32'(bus.inst_valid),     32'd0);
        check("t7 async req_valid",  32'(bus.imem_req_valid), 32'd0);
        check("t7 async count",      32'(bus.fifo_count),     32'd0);
        check("t7 async req_addr",   bus.imem_req_addr,       32'h0);
        mem_lat = 1;
        bus.inst_ready = 1'b1;
        step();
        reset = 1'b1;
        for (int i = 0; i < 30 && !bus.imem_req_valid; i++) step();
        check("t7 resume req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t7 resume req_addr",  bus.imem_req_addr,       32'h0);
        for (int i = 0; i < 30 && !bus.inst_valid; i++) step();
        check("t7 resume inst_pc",   bus.inst_pc,   32'h0);
        check("t7 resume inst_data", bus.inst_data, 32'hA5A5_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
